// File: rtl/fp_addsub_seq_if.sv
// Handshake and data bundle between the operand source and fp_addsub_seq.
// The master launches operations; the slave (the adder) reports results.
interface fp_addsub_seq_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  modport master (
    output start, op, a, b,
    input  busy, done, result, overflow, underflow, invalid
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle single-precision add/subtract built around one shared 24-bit
// add/sub unit; truncating, denormals flushed to zero.
module fp_addsub_seq #(
  parameter int unsigned ALIGN_SKIP = 25
) (
  input logic          clk,
  input logic          rst,
  fp_addsub_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, UNPACK, EXP, EXP2, MCMP, ALIGN, ADD, NORM, PACK
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q, b_q;
  logic        op_q;
  logic [7:0]  ea, eb, diff;
  logic [23:0] ma, mb;
  logic        sa, sb;
  logic [24:0] sum;
  logic [31:0] pack_val;
  logic        ovf_p, unf_p, inv_p;

  logic [23:0] au_x, au_y, au_res;
  logic        au_sub, au_cout;
  logic        special, skip;
  logic [24:0] add_sum;

  // Shared unit: subtract sets carry-in, so cout=1 means x >= y.
  always_comb begin
    au_x   = '0;
    au_y   = '0;
    au_sub = 1'b0;
    case (state)
      EXP, EXP2: begin
        au_x   = {16'd0, ea};
        au_y   = {16'd0, eb};
        au_sub = 1'b1;
      end
      MCMP: begin
        au_x   = ma;
        au_y   = mb;
        au_sub = 1'b1;
      end
      ADD: begin
        au_x   = ma;
        au_y   = mb;
        au_sub = sa ^ sb;
      end
      default: ;
    endcase
    {au_cout, au_res} = {1'b0, au_x} + {1'b0, au_y ^ {24{au_sub}}} + {24'd0, au_sub};
  end

  assign special = (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
  assign skip    = {24'd0, diff} >= ALIGN_SKIP;
  assign add_sum = {au_cout & ~(sa ^ sb), au_res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.start) state_nxt = UNPACK;
      UNPACK: state_nxt = special ? PACK : EXP;
      EXP: begin
        if (!au_cout)                 state_nxt = EXP2;
        else if (au_res[7:0] == 8'd0) state_nxt = MCMP;
        else                          state_nxt = ALIGN;
      end
      EXP2:   state_nxt = (au_res[7:0] == 8'd0) ? MCMP : ALIGN;
      MCMP:   state_nxt = ADD;
      ALIGN:  if (skip || diff <= 8'd1) state_nxt = ADD;
      ADD:    state_nxt = (add_sum == 25'd0) ? PACK : NORM;
      NORM: begin
        if (sum[24])      begin if (ea == 8'd254) state_nxt = PACK; end
        else if (sum[23]) state_nxt = PACK;
        else if (ea == 8'd1) state_nxt = PACK;
      end
      PACK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; op_q <= 1'b0;
      ea <= '0; eb <= '0; diff <= '0;
      ma <= '0; mb <= '0; sa <= 1'b0; sb <= 1'b0;
      sum <= '0; pack_val <= '0;
      ovf_p <= 1'b0; unf_p <= 1'b0; inv_p <= 1'b0;
      bus.busy <= 1'b0; bus.done <= 1'b0; bus.result <= '0;
      bus.overflow <= 1'b0; bus.underflow <= 1'b0; bus.invalid <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_q <= bus.a; b_q <= bus.b; op_q <= bus.op;
          bus.busy <= 1'b1;
          ovf_p <= 1'b0; unf_p <= 1'b0; inv_p <= 1'b0;
          bus.overflow <= 1'b0; bus.underflow <= 1'b0; bus.invalid <= 1'b0;
        end
        UNPACK: begin
          ea <= a_q[30:23];
          eb <= b_q[30:23];
          ma <= (a_q[30:23] == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
          mb <= (b_q[30:23] == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
          sa <= a_q[31];
          sb <= b_q[31] ^ op_q;
          if (special) begin
            pack_val <= 32'h7FC00000;
            inv_p    <= 1'b1;
          end
        end
        EXP: begin
          if (au_cout) diff <= au_res[7:0];
          else begin
            ea <= eb; eb <= ea; ma <= mb; mb <= ma; sa <= sb; sb <= sa;
          end
        end
        EXP2: diff <= au_res[7:0];
        // Equal exponents: order by mantissa so the subtract never borrows.
        MCMP: if (!au_cout) begin
          ma <= mb; mb <= ma; sa <= sb; sb <= sa;
        end
        ALIGN: begin
          if (skip) begin
            mb   <= '0;
            diff <= '0;
          end else begin
            mb   <= mb >> 1;
            diff <= diff - 8'd1;
          end
        end
        ADD: begin
          sum <= add_sum;
          if (add_sum == 25'd0) pack_val <= 32'h0;
        end
        NORM: begin
          if (sum[24]) begin
            sum <= sum >> 1;
            ea  <= ea + 8'd1;
            if (ea == 8'd254) begin
              pack_val <= {sa, 31'h7F800000};
              ovf_p    <= 1'b1;
            end
          end else if (sum[23]) begin
            pack_val <= {sa, ea, sum[22:0]};
          end else begin
            sum <= sum << 1;
            ea  <= ea - 8'd1;
            if (ea == 8'd1) begin
              pack_val <= 32'h0;
              unf_p    <= 1'b1;
            end
          end
        end
        PACK: begin
          bus.result    <= pack_val;
          bus.overflow  <= ovf_p;
          bus.underflow <= unf_p;
          bus.invalid   <= inv_p;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
